// File: rtl/projectile_pool_ctrl_if.sv
// Handshake and slot-state bundle between the player/input logic and the projectile pool.
interface projectile_pool_ctrl_if #(
    parameter int unsigned NUM_SLOTS = 4
);
    logic                      frame_tick;
    logic                      shoot;
    logic [9:0]                playerx;
    logic                      hit_valid;
    logic [2:0]                hit_slot;
    logic [NUM_SLOTS-1:0]      slot_exists;
    logic [10*NUM_SLOTS-1:0]   slot_x;
    logic [10*NUM_SLOTS-1:0]   slot_y;
    logic                      fire_ack;
    logic                      fire_drop;
    logic                      overrun;

    modport master (
        output frame_tick, shoot, playerx, hit_valid, hit_slot,
        input  slot_exists, slot_x, slot_y, fire_ack, fire_drop, overrun
    );

    modport slave (
        input  frame_tick, shoot, playerx, hit_valid, hit_slot,
        output slot_exists, slot_x, slot_y, fire_ack, fire_drop, overrun
    );
endinterface

// File: rtl/projectile_pool_ctrl.sv
// Projectile slot pool: captures fire requests and runs one spawn-then-move pass per frame_tick.
module projectile_pool_ctrl #(
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned SPEED     = 4,
    parameter int unsigned SPAWN_Y   = 448,
    parameter int unsigned X_OFFSET  = 30,
    parameter int unsigned COOLDOWN  = 8
) (
    input logic                   clk,
    input logic                   rst,
    projectile_pool_ctrl_if.slave bus
);
    localparam int unsigned IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    typedef enum logic [1:0] {StIdle, StSpawn, StMove, StDone} state_e;

    state_e               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [7:0]           cool_q, cool_d;
    logic                 pending_q, pending_d;
    logic                 shoot_q;
    logic [NUM_SLOTS-1:0] exists_q, exists_d;
    logic [NUM_SLOTS-1:0] fresh_q, fresh_d;
    logic [9:0]           x_q [NUM_SLOTS];
    logic [9:0]           x_d [NUM_SLOTS];
    logic [9:0]           y_q [NUM_SLOTS];
    logic [9:0]           y_d [NUM_SLOTS];
    logic                 ack_q, ack_d, drop_q, drop_d, overrun_q, overrun_d;

    logic                 shoot_rise, free_found, hit_ok;
    logic [IW-1:0]        free_idx, hit_idx;

    assign shoot_rise = bus.shoot & ~shoot_q;
    assign hit_idx    = bus.hit_slot[IW-1:0];
    // Out-of-range slot numbers are rejected before the aliased low bits are used.
    assign hit_ok     = bus.hit_valid && ({29'd0, bus.hit_slot} < NUM_SLOTS) && exists_q[hit_idx];

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!exists_q[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= StIdle;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.frame_tick) state_d = StSpawn;
            StSpawn: state_d = StMove;
            StMove:  if (idx_q == IW'(NUM_SLOTS - 1)) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        exists_d  = exists_q;
        fresh_d   = fresh_q;
        x_d       = x_q;
        y_d       = y_q;
        cool_d    = cool_q;
        idx_d     = idx_q;
        pending_d = pending_q | shoot_rise;
        ack_d     = 1'b0;
        drop_d    = 1'b0;
        overrun_d = bus.frame_tick && (state_q != StIdle);

        unique case (state_q)
            StSpawn: begin
                idx_d = '0;
                if (cool_q != 8'd0) begin
                    cool_d = cool_q - 8'd1;
                end else if (pending_q && free_found) begin
                    exists_d[free_idx] = 1'b1;
                    fresh_d[free_idx]  = 1'b1;
                    x_d[free_idx]      = bus.playerx + 10'(X_OFFSET);
                    y_d[free_idx]      = 10'(SPAWN_Y);
                    ack_d              = 1'b1;
                    cool_d             = 8'(COOLDOWN);
                    pending_d          = shoot_rise;
                end else if (pending_q) begin
                    drop_d    = 1'b1;
                    pending_d = shoot_rise;
                end
            end
            StMove: begin
                idx_d = idx_q + IW'(1);
                if (exists_q[idx_q] && !fresh_q[idx_q]) begin
                    if (y_q[idx_q] < 10'(SPEED)) begin
                        exists_d[idx_q] = 1'b0;
                        x_d[idx_q]      = '0;
                        y_d[idx_q]      = '0;
                    end else begin
                        y_d[idx_q] = y_q[idx_q] - 10'(SPEED);
                    end
                end
            end
            StDone:  fresh_d = '0;
            default: ;
        endcase

        // Applied last so a hit overrides the move; the slot being spawned is still dead in
        // exists_q, so a same-cycle hit on it never fires.
        if (hit_ok) begin
            exists_d[hit_idx] = 1'b0;
            x_d[hit_idx]      = '0;
            y_d[hit_idx]      = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q     <= '0;
            cool_q    <= '0;
            pending_q <= 1'b0;
            shoot_q   <= 1'b0;
            exists_q  <= '0;
            fresh_q   <= '0;
            ack_q     <= 1'b0;
            drop_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            idx_q     <= idx_d;
            cool_q    <= cool_d;
            pending_q <= pending_d;
            shoot_q   <= bus.shoot;
            exists_q  <= exists_d;
            fresh_q   <= fresh_d;
            ack_q     <= ack_d;
            drop_q    <= drop_d;
            overrun_q <= overrun_d;
            x_q       <= x_d;
            y_q       <= y_d;
        end
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_out
        assign bus.slot_x[10*i +: 10] = x_q[i];
        assign bus.slot_y[10*i +: 10] = y_q[i];
    end

    assign bus.slot_exists = exists_q;
    assign bus.fire_ack    = ack_q;
    assign bus.fire_drop   = drop_q;
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_projectile_pool_ctrl.sv
// Bench for projectile_pool_ctrl: two instances (cooldown 8 and 0) fed identical stimulus and
// checked per frame against a frame-level model, plus constant-table and corner sequences.
module tb_projectile_pool_ctrl;
    localparam int N    = 4;
    localparam int CD_A = 8;
    localparam int CD_B = 0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    projectile_pool_ctrl_if #(.NUM_SLOTS(N)) bus_a ();
    projectile_pool_ctrl_if #(.NUM_SLOTS(N)) bus_b ();

    assign bus_b.frame_tick = bus_a.frame_tick;
    assign bus_b.shoot      = bus_a.shoot;
    assign bus_b.playerx    = bus_a.playerx;
    assign bus_b.hit_valid  = bus_a.hit_valid;
    assign bus_b.hit_slot   = bus_a.hit_slot;

    projectile_pool_ctrl #(.NUM_SLOTS(N), .COOLDOWN(CD_A)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    projectile_pool_ctrl #(.NUM_SLOTS(N), .COOLDOWN(CD_B)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int checks = 0;
    int failures = 0;

    // Frame-level reference model, index 0 = dut_a, 1 = dut_b.
    bit m_ex   [2][N];
    int m_x    [2][N];
    int m_y    [2][N];
    bit m_pend [2];
    int m_cool [2];
    int exp_ack [2];
    int exp_drop [2];
    int got_ack [2];
    int got_drop [2];
    int got_ovr [2];

    typedef struct {
        int hit;
        int ack_a, drop_a, ex_a;
        int ack_b, drop_b, ex_b;
        int y_a0;
    } vec_t;
    vec_t tbl [19];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int dut_ex(input int i);
        return (i == 0) ? int'(bus_a.slot_exists) : int'(bus_b.slot_exists);
    endfunction

    function automatic int dut_x(input int i, input int s);
        logic [10*N-1:0] v;
        v = (i == 0) ? bus_a.slot_x : bus_b.slot_x;
        return int'(v[10*s +: 10]);
    endfunction

    function automatic int dut_y(input int i, input int s);
        logic [10*N-1:0] v;
        v = (i == 0) ? bus_a.slot_y : bus_b.slot_y;
        return int'(v[10*s +: 10]);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = 1'b0;
            m_cool[i] = 0;
            for (int s = 0; s < N; s++) begin
                m_ex[i][s] = 1'b0;
                m_x[i][s]  = 0;
                m_y[i][s]  = 0;
            end
        end
    endtask

    task automatic m_hit(input int s);
        if (s < N) begin
            for (int i = 0; i < 2; i++) begin
                if (m_ex[i][s]) begin
                    m_ex[i][s] = 1'b0;
                    m_x[i][s]  = 0;
                    m_y[i][s]  = 0;
                end
            end
        end
    endtask

    task automatic m_frame(input int px);
        for (int i = 0; i < 2; i++) begin
            int fresh;
            int free;
            fresh = -1;
            exp_ack[i]  = 0;
            exp_drop[i] = 0;
            if (m_cool[i] > 0) begin
                m_cool[i]--;
            end else if (m_pend[i]) begin
                free = -1;
                for (int s = N - 1; s >= 0; s--) if (!m_ex[i][s]) free = s;
                if (free >= 0) begin
                    m_ex[i][free] = 1'b1;
                    m_x[i][free]  = (px + 30) % 1024;
                    m_y[i][free]  = 448;
                    fresh         = free;
                    exp_ack[i]    = 1;
                    m_cool[i]     = (i == 0) ? CD_A : CD_B;
                end else begin
                    exp_drop[i] = 1;
                end
                m_pend[i] = 1'b0;
            end
            for (int s = 0; s < N; s++) begin
                if (s != fresh && m_ex[i][s]) begin
                    if (m_y[i][s] < 4) begin
                        m_ex[i][s] = 1'b0;
                        m_x[i][s]  = 0;
                        m_y[i][s]  = 0;
                    end else begin
                        m_y[i][s] -= 4;
                    end
                end
            end
        end
    endtask

    task automatic cmp_state(input string tag);
        for (int i = 0; i < 2; i++) begin
            int e;
            e = 0;
            for (int s = 0; s < N; s++) if (m_ex[i][s]) e |= (1 << s);
            check($sformatf("%s exists dut%0d", tag, i), dut_ex(i), e);
            for (int s = 0; s < N; s++) begin
                check($sformatf("%s x dut%0d slot%0d", tag, i, s), dut_x(i, s), m_x[i][s]);
                check($sformatf("%s y dut%0d slot%0d", tag, i, s), dut_y(i, s), m_y[i][s]);
            end
        end
    endtask

    task automatic cmp_zero(input string tag);
        check({tag, " exists a"}, dut_ex(0), 0);
        check({tag, " exists b"}, dut_ex(1), 0);
        check({tag, " x a"}, int'(bus_a.slot_x != '0), 0);
        check({tag, " y a"}, int'(bus_a.slot_y != '0), 0);
        check({tag, " x b"}, int'(bus_b.slot_x != '0), 0);
        check({tag, " y b"}, int'(bus_b.slot_y != '0), 0);
        check({tag, " flags a"}, int'({bus_a.fire_ack, bus_a.fire_drop, bus_a.overrun}), 0);
        check({tag, " flags b"}, int'({bus_b.fire_ack, bus_b.fire_drop, bus_b.overrun}), 0);
    endtask

    task automatic pulse_shoot();
        @(negedge clk);
        bus_a.shoot = 1'b1;
        @(negedge clk);
        bus_a.shoot = 1'b0;
        m_pend[0] = 1'b1;
        m_pend[1] = 1'b1;
    endtask

    task automatic pulse_hit(input int s);
        @(negedge clk);
        bus_a.hit_valid = 1'b1;
        bus_a.hit_slot  = 3'(s);
        @(negedge clk);
        bus_a.hit_valid = 1'b0;
        m_hit(s);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m_reset();
    endtask

    // One frame: tick, optional hit at window cycle hit_cycle (2..6 lands in MOVE/DONE),
    // optional second tick at window cycle extra_tick. Pulses are counted over the window.
    task automatic run_frame(input int hit_cycle, input int hslot, input int extra_tick);
        for (int i = 0; i < 2; i++) begin
            got_ack[i]  = 0;
            got_drop[i] = 0;
            got_ovr[i]  = 0;
        end
        @(negedge clk);
        bus_a.frame_tick = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            got_ack[0]  += int'(bus_a.fire_ack);
            got_drop[0] += int'(bus_a.fire_drop);
            got_ovr[0]  += int'(bus_a.overrun);
            got_ack[1]  += int'(bus_b.fire_ack);
            got_drop[1] += int'(bus_b.fire_drop);
            got_ovr[1]  += int'(bus_b.overrun);
            bus_a.frame_tick = (c == extra_tick);
            bus_a.hit_valid  = (c == hit_cycle);
            bus_a.hit_slot   = 3'(hslot);
        end
        m_frame(int'(bus_a.playerx));
        if (hit_cycle > 0) m_hit(hslot);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("fire_ack count dut%0d", i), got_ack[i], exp_ack[i]);
            check($sformatf("fire_drop count dut%0d", i), got_drop[i], exp_drop[i]);
            check($sformatf("overrun count dut%0d", i), got_ovr[i], (extra_tick > 0) ? 1 : 0);
        end
        cmp_state("frame");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.frame_tick = 1'b0;
        bus_a.shoot      = 1'b0;
        bus_a.playerx    = 10'd100;
        bus_a.hit_valid  = 1'b0;
        bus_a.hit_slot   = 3'd0;
        m_reset();

        // hit, ack_a, drop_a, ex_a, ack_b, drop_b, ex_b, y of dut_a slot0
        tbl[0]  = '{-1, 1, 0, 1, 1, 0,  1, 448};
        tbl[1]  = '{-1, 0, 0, 1, 1, 0,  3, 444};
        tbl[2]  = '{-1, 0, 0, 1, 1, 0,  7, 440};
        tbl[3]  = '{-1, 0, 0, 1, 1, 0, 15, 436};
        tbl[4]  = '{-1, 0, 0, 1, 0, 1, 15, 432};
        tbl[5]  = '{-1, 0, 0, 1, 0, 1, 15, 428};
        tbl[6]  = '{ 6, 0, 0, 1, 0, 1, 15, 424};
        tbl[7]  = '{ 1, 0, 0, 1, 1, 0, 15, 420};
        tbl[8]  = '{-1, 0, 0, 1, 0, 1, 15, 416};
        tbl[9]  = '{-1, 1, 0, 3, 0, 1, 15, 412};
        tbl[10] = '{-1, 0, 0, 3, 0, 1, 15, 408};
        tbl[11] = '{ 0, 0, 0, 2, 1, 0, 15,   0};
        for (int r = 12; r < 18; r++) tbl[r] = '{-1, 0, 0, 2, 0, 1, 15, 0};
        tbl[18] = '{-1, 1, 0, 3, 0, 1, 15, 448};

        repeat (3) @(negedge clk);
        cmp_zero("reset");
        rst = 1'b1;

        // Every frame gets a fresh shoot edge: cooldown spaces dut_a spawns 9 frames apart,
        // dut_b fills the pool and then drops.
        for (int r = 0; r < 19; r++) begin
            if (tbl[r].hit >= 0) pulse_hit(tbl[r].hit);
            pulse_shoot();
            run_frame(-1, 0, 0);
            check($sformatf("tbl%0d ack a", r), got_ack[0], tbl[r].ack_a);
            check($sformatf("tbl%0d drop a", r), got_drop[0], tbl[r].drop_a);
            check($sformatf("tbl%0d exists a", r), dut_ex(0), tbl[r].ex_a);
            check($sformatf("tbl%0d ack b", r), got_ack[1], tbl[r].ack_b);
            check($sformatf("tbl%0d drop b", r), got_drop[1], tbl[r].drop_b);
            check($sformatf("tbl%0d exists b", r), dut_ex(1), tbl[r].ex_b);
            check($sformatf("tbl%0d y a slot0", r), dut_y(0, 0), tbl[r].y_a0);
            if (r == 0) check("tbl0 x a slot0", dut_x(0, 0), 130);
        end

        // Reset during MOVE wipes everything; the next frame runs normally.
        @(negedge clk);
        bus_a.frame_tick = 1'b1;
        @(negedge clk);
        bus_a.frame_tick = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        cmp_zero("mid-frame reset");
        @(negedge clk);
        rst = 1'b1;
        m_reset();

        bus_a.playerx = 10'd100;
        pulse_shoot();
        run_frame(-1, 0, 0);
        check("life spawn ack", got_ack[0], 1);
        check("life spawn x", dut_x(0, 0), 130);
        check("life spawn y", dut_y(0, 0), 448);
        run_frame(-1, 0, 0);
        check("life first move y", dut_y(0, 0), 444);
        for (int f = 0; f < 111; f++) run_frame(-1, 0, 0);
        check("life 112 moves exists", dut_ex(0), 1);
        check("life 112 moves y", dut_y(0, 0), 0);
        run_frame(-1, 0, 0);
        check("life died exists", dut_ex(0), 0);

        // Held button: only the first rising edge requests.
        @(negedge clk);
        bus_a.shoot = 1'b1;
        m_pend[0] = 1'b1;
        m_pend[1] = 1'b1;
        run_frame(-1, 0, 0);
        check("hold first ack b", got_ack[1], 1);
        run_frame(-1, 0, 0);
        check("hold second ack b", got_ack[1], 0);
        @(negedge clk);
        bus_a.shoot = 1'b0;

        // Hit racing the MOVE of the same slot.
        pulse_rst();
        pulse_shoot();
        run_frame(-1, 0, 0);
        pulse_shoot();
        run_frame(-1, 0, 0);
        for (int f = 0; f < 62; f++) run_frame(-1, 0, 0);
        check("collide setup y b slot1", dut_y(1, 1), 200);
        run_frame(3, 1, 0);
        check("collide exists b slot1", (dut_ex(1) >> 1) & 1, 0);
        check("collide y b slot1", dut_y(1, 1), 0);
        run_frame(3, 6, 0);
        check("hit slot6 ignored b", dut_ex(1), 1);

        // Second tick while busy: overrun pulse, single update (checked inside run_frame).
        run_frame(-1, 0, 2);

        for (int k = 0; k < 150; k++) begin
            int hc;
            bus_a.playerx = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) == 0) pulse_hit(int'($urandom_range(0, 7)));
            if ($urandom_range(0, 1) == 1) pulse_shoot();
            hc = ($urandom_range(0, 4) == 0) ? int'($urandom_range(2, 6)) : -1;
            run_frame(hc, int'($urandom_range(0, 7)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
